wb_dec_n: RTL and testbench

WB_DEC_N -- requirements
Module: wb_dec_n

---
 rtl/wb_dec_n.sv | 138 +++++++++++++
 tb/tb_wb_dec_n.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dec_n.sv
// Wishbone address decoder: routes one master to NS slaves by base/mask match.
// Build with WB_DEC_N_TIMEOUT_EN defined to add an ACTIVE-state watchdog that errors out stalled slaves.
module wb_dec_n #(
  parameter int AW = 30,
  parameter int DW = 32,
  parameter int NS = 4,
  parameter logic [NS*AW-1:0] SLV_BASE = default_base(),
  parameter logic [NS*AW-1:0] SLV_MASK = default_mask(),
  parameter int TO_CYC = 256
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic [AW-1:0]    adr_i,
  output logic             ack_o,
  output logic             err_o,
  output logic [DW-1:0]    dat_o,
  output logic             busy_o,
  output logic [NS-1:0]    s_stb_o,
  input  logic [NS-1:0]    s_ack_i,
  input  logic [NS*DW-1:0] s_dat_i
);

  // Default map splits the word address space into quarters on the top two bits.
  function automatic logic [NS*AW-1:0] default_base();
    logic [NS*AW-1:0] v;
    v = '0;
    for (int k = 0; k < NS; k++)
      v[k*AW +: AW] = AW'(k) << (AW-2);
    return v;
  endfunction

  function automatic logic [NS*AW-1:0] default_mask();
    logic [NS*AW-1:0] v;
    v = '0;
    for (int k = 0; k < NS; k++)
      v[k*AW +: AW] = {2'b11, {(AW-2){1'b0}}};
    return v;
  endfunction

  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] sel;
  logic          hit;
  logic [IW-1:0] hit_idx;

`ifdef WB_DEC_N_TIMEOUT_EN
  localparam int CW = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
  logic [CW-1:0] to_cnt;
`endif

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NS-1; k >= 0; k--) begin
      if ((adr_i & SLV_MASK[k*AW +: AW]) == (SLV_BASE[k*AW +: AW] & SLV_MASK[k*AW +: AW])) begin
        hit     = 1'b1;
        hit_idx = IW'(k);
      end
    end
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      dat_o   <= '0;
      s_stb_o <= '0;
      sel     <= '0;
`ifdef WB_DEC_N_TIMEOUT_EN
      to_cnt  <= '0;
`endif
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cyc_i && stb_i) begin
            if (hit) begin
              sel     <= hit_idx;
              s_stb_o <= NS'(1) << hit_idx;
              state   <= ACTIVE;
`ifdef WB_DEC_N_TIMEOUT_EN
              to_cnt  <= '0;
`endif
            end else begin
              err_o <= 1'b1;
              dat_o <= '0;
              state <= RESP;
            end
          end
        end
        ACTIVE: begin
          // Abort outranks a same-cycle ack; a slave ack outranks the timeout.
          if (!cyc_i) begin
            s_stb_o <= '0;
            state   <= IDLE;
          end else if (s_ack_i[sel]) begin
            dat_o   <= s_dat_i[sel*DW +: DW];
            ack_o   <= 1'b1;
            s_stb_o <= '0;
            state   <= RESP;
          end
`ifdef WB_DEC_N_TIMEOUT_EN
          else if (to_cnt == CW'(TO_CYC-1)) begin
            err_o   <= 1'b1;
            dat_o   <= '0;
            s_stb_o <= '0;
            state   <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          s_stb_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dec_n.sv
// Scoreboard bench for wb_dec_n: stimulus queues expected responses, a monitor pops them on ack/err.
module tb_wb_dec_n;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             cyc_i, stb_i;
  logic [AW-1:0]    adr_i;
  logic             ack_o, err_o, busy_o;
  logic [DW-1:0]    dat_o;
  logic [NS-1:0]    s_stb_o;
  logic [NS-1:0]    s_ack_i;
  logic [NS*DW-1:0] s_dat_i;

  wb_dec_n #(.AW(AW), .DW(DW), .NS(NS), .TO_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .adr_i(adr_i),
    .ack_o(ack_o), .err_o(err_o), .dat_o(dat_o), .busy_o(busy_o),
    .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            err;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         exp_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] last_dat = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Default map: the top two address bits name the slave; quarters beyond NS are holes.
  function automatic int ref_slave(input logic [AW-1:0] a);
    int q;
    q = int'(a / (1 << (AW-2)));
    return (q < NS) ? q : -1;
  endfunction

  always @(negedge clk) begin : monitor
    resp_t e;
    if (!rst_i && (ack_o || err_o)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: ack=%0b err=%0b dat=0x%0h, expected no response", ack_o, err_o, dat_o);
      end else begin
        e = exp_q.pop_front();
        check("resp_err", 32'(err_o), 32'(e.err));
        check("resp_ack", 32'(ack_o), 32'(!e.err));
        check("resp_dat", dat_o, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [AW-1:0] addr, input int delay,
                         input logic [DW-1:0] data, input logic [NS-1:0] other);
    int               s;
    logic [NS-1:0]    me;
    logic [NS*DW-1:0] bus;
    s = ref_slave(addr);
    cyc_i = 1'b1; stb_i = 1'b1; adr_i = addr;
    if (s < 0) begin
      exp_q.push_back('{err: 1'b1, data: '0});
      last_dat = '0;
      tick();
      check("unmapped_stb", 32'(s_stb_o), 32'(0));
      check("unmapped_busy", 32'(busy_o), 32'(1));
      cyc_i = 1'b0; stb_i = 1'b0;
      tick();
      check("unmapped_busy_end", 32'(busy_o), 32'(0));
    end else begin
      me = NS'(1) << s;
      exp_q.push_back('{err: 1'b0, data: data});
      last_dat = data;
      tick();
      check("stb_sel", 32'(s_stb_o), 32'(me));
      for (int d = 0; d < delay; d++) begin
        s_ack_i = other & ~me;
        s_dat_i = {$urandom, $urandom, $urandom};
        tick();
        check("stb_hold", 32'(s_stb_o), 32'(me));
      end
      bus = {$urandom, $urandom, $urandom};
      bus[s*DW +: DW] = data;
      s_dat_i = bus;
      s_ack_i = (other & ~me) | me;
      tick();
      check("stb_clear", 32'(s_stb_o), 32'(0));
      cyc_i = 1'b0; stb_i = 1'b0; s_ack_i = '0;
      tick();
      check("idle_after_resp", 32'(busy_o), 32'(0));
    end
  endtask

  task automatic abort_txn(input logic [AW-1:0] addr, input bit with_ack);
    logic [NS-1:0] me;
    me = NS'(1) << ref_slave(addr);
    cyc_i = 1'b1; stb_i = 1'b1; adr_i = addr;
    tick();
    check("abort_stb1", 32'(s_stb_o), 32'(me));
    tick();
    check("abort_stb2", 32'(s_stb_o), 32'(me));
    cyc_i = 1'b0; stb_i = 1'b0;
    s_ack_i = with_ack ? me : '0;
    s_dat_i = {$urandom, $urandom, $urandom};
    tick();
    check("abort_stb_clear", 32'(s_stb_o), 32'(0));
    check("abort_busy", 32'(busy_o), 32'(0));
    s_ack_i = me;
    tick();
    check("late_ack_busy", 32'(busy_o), 32'(0));
    check("late_ack_stb", 32'(s_stb_o), 32'(0));
    check("dat_hold", dat_o, last_dat);
    s_ack_i = '0;
    tick();
  endtask

  initial begin
    int n;
    rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; adr_i = '0; s_ack_i = '0; s_dat_i = '0;
    repeat (3) tick();
    check("rst_ack", 32'(ack_o), 32'(0));
    check("rst_err", 32'(err_o), 32'(0));
    check("rst_dat", dat_o, 32'(0));
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_stb", 32'(s_stb_o), 32'(0));
    rst_i = 1'b0;

    // First request issued in the very first cycle out of reset.
    run_txn(30'h1000_0004, 0, 32'hDEAD_BEEF, 3'b000);
    check("dat_after_ack", dat_o, 32'hDEAD_BEEF);
    run_txn(30'h3000_0000, 0, 32'h0, 3'b000);
    check("dat_after_err", dat_o, 32'h0);
    run_txn(30'h2000_0010, 3, 32'h2222_2222, 3'b001);
    abort_txn(30'h0000_0040, 1'b0);
    run_txn(30'h0000_0008, TO-1, 32'hA5A5_5A5A, 3'b110);
    abort_txn(30'h1000_0000, 1'b1);

`ifdef WB_DEC_N_TIMEOUT_EN
    exp_q.push_back('{err: 1'b1, data: '0});
    last_dat = '0;
    cyc_i = 1'b1; stb_i = 1'b1; adr_i = 30'h0000_0100;
    tick();
    n = 0;
    while (s_stb_o != '0 && n < 200) begin
      n++;
      tick();
    end
    check("timeout_stb_cycles", 32'(n), 32'(TO));
    cyc_i = 1'b0; stb_i = 1'b0;
    tick();
    check("timeout_idle", 32'(busy_o), 32'(0));
`else
    cyc_i = 1'b1; stb_i = 1'b1; adr_i = 30'h0000_0100;
    tick();
    n = 0;
    for (int i = 0; i < 120; i++) begin
      if (s_stb_o == 3'b001) n++;
      tick();
    end
    check("no_timeout_stb_cycles", 32'(n), 32'(120));
    cyc_i = 1'b0; stb_i = 1'b0;
    tick();
    check("no_timeout_abort", 32'(busy_o), 32'(0));
`endif

    // Reset asserted in the middle of an ACTIVE cycle.
    cyc_i = 1'b1; stb_i = 1'b1; adr_i = 30'h1000_0020;
    tick();
    check("pre_rst_stb", 32'(s_stb_o), 32'(3'b010));
    #2 rst_i = 1'b1;
    #1;
    check("mid_rst_stb", 32'(s_stb_o), 32'(0));
    check("mid_rst_busy", 32'(busy_o), 32'(0));
    check("mid_rst_dat", dat_o, 32'(0));
    check("mid_rst_ack", 32'(ack_o | err_o), 32'(0));
    cyc_i = 1'b0; stb_i = 1'b0;
    last_dat = '0;
    tick();
    rst_i = 1'b0;
    run_txn(30'h1000_0004, 1, 32'h1234_5678, 3'b101);

    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom);
      if (i % 7 == 3 && ref_slave(a) >= 0)
        abort_txn(a, 1'($urandom));
      else
        run_txn(a, int'($urandom_range(0, 5)), $urandom, NS'($urandom));
    end

    repeat (2) tick();
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
